adder_share_arbiter: RTL



---
 rtl/adder_share_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Shares one N-bit adder between NREQ requesters with round-robin grant into a single result slot.
// Latency: result is valid one cycle after the accept edge; drain and refill can overlap in one cycle.
// Backpressure: while the slot is full and res_ready is low, no requester is granted and the result holds.
module adder_share_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N:0]        res_sum,
    output logic [IDW-1:0]    res_id,
    output logic [CW-1:0]     ops_done,
    output logic              busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e          slot_q, slot_d;
    logic [N:0]     res_sum_q, res_sum_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  ops_done_q, ops_done_d;

    logic           load_ok;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   scan;
    logic           do_grant;
    logic [N-1:0]   a_sel, b_sel;
    logic           handoff;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[scan[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IDW-1:0];
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel = req_a[i*N +: N];
                b_sel = req_b[i*N +: N];
            end
        end
    end

    always_comb begin
        load_ok  = (slot_q == EMPTY) || res_ready;
        do_grant = load_ok && gnt_found;
        handoff  = (slot_q == FULL) && res_ready;

        req_ready = '0;
        if (do_grant && rst_n) begin
            req_ready[gnt_idx] = 1'b1;
        end

        slot_d     = slot_q;
        res_sum_d  = res_sum_q;
        res_id_d   = res_id_q;
        ptr_d      = ptr_q;
        ops_done_d = ops_done_q + (handoff ? CW'(1) : CW'(0));

        if (do_grant) begin
            slot_d    = FULL;
            res_sum_d = {1'b0, a_sel} + {1'b0, b_sel};
            res_id_d  = gnt_idx;
            ptr_d     = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
        end else if (handoff) begin
            slot_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= EMPTY;
            res_sum_q  <= '0;
            res_id_q   <= '0;
            ptr_q      <= '0;
            ops_done_q <= '0;
        end else begin
            slot_q     <= slot_d;
            res_sum_q  <= res_sum_d;
            res_id_q   <= res_id_d;
            ptr_q      <= ptr_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign res_valid = (slot_q == FULL);
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign ops_done  = ops_done_q;
    assign busy      = res_valid || (|req_valid);

endmodule
